// File: rtl/seg7_pkg.sv
// Shared types and constants for the 8-digit 7-segment scan controller.
package seg7_pkg;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

  // All segments off (segments are active-low).
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Hex nibble -> active-low segments, bit6 = a down to bit0 = g.
  localparam logic [6:0] SEG_DECODE [0:15] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low 7-segment decoder.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_DECODE[nibble];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 8-digit 7-segment scan controller with per-slot blanking and
// frame-aligned double-buffered value updates.
// Optional build macro SEG7_LZB_EN enables leading-zero blanking.
//
// state | meaning
// OFF   | display dark, waiting for i_enable
// BLANK | first BLANK_CYCLES of a digit slot, all anodes off
// SHOW  | rest of the slot, current digit driven
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_enable,
  input  logic [31:0] i_value,
  input  logic        i_load,
  input  logic [7:0]  i_dp_mask,
  output logic [7:0]  o_an,
  output logic [6:0]  o_seg,
  output logic        o_dp,
  output logic        o_frame_done
);

  localparam int CW = $clog2(DIGIT_CYCLES);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(DIGIT_CYCLES - 1);
  // frame_done is raised one cycle early so that it is visible on the
  // same cycle the frame-boundary commit is taken.
  localparam logic [CW-1:0] FRAME_MARK = CW'(DIGIT_CYCLES - 2);

  state_t        state, next_state;
  logic [CW-1:0] cnt, next_cnt;
  logic [2:0]    digit, next_digit;
  logic          commit;

  logic [31:0]   display, pending;
  logic          pend_flag;

  logic [3:0]    nibble;
  logic [6:0]    dec_seg;
  logic          lead_zero;

  logic [7:0]    next_an;
  logic [6:0]    next_seg;
  logic          next_dp, next_frame_done;

  assign nibble = display[{digit, 2'b00} +: 4];

  seg7_hex_decode u_hex_decode (
    .nibble (nibble),
    .seg    (dec_seg)
  );

`ifdef SEG7_LZB_EN
  assign lead_zero = (digit != 3'd0) && ((display >> {digit, 2'b00}) == 32'd0);
`else
  assign lead_zero = 1'b0;
`endif

  // State, slot counter and digit index registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= ST_OFF;
      cnt   <= '0;
      digit <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
      digit <= next_digit;
    end
  end

  // Next-state logic; disable overrides everything and parks in OFF.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    next_digit = digit;
    commit     = 1'b0;
    if (!i_enable) begin
      next_state = ST_OFF;
      next_cnt   = '0;
      next_digit = '0;
    end else begin
      case (state)
        ST_OFF: begin
          commit     = 1'b1;
          next_state = ST_BLANK;
          next_cnt   = '0;
          next_digit = '0;
        end
        ST_BLANK: begin
          next_cnt = cnt + CW'(1);
          if (cnt == BLANK_LAST) next_state = ST_SHOW;
        end
        ST_SHOW: begin
          if (cnt == SLOT_LAST) begin
            next_state = ST_BLANK;
            next_cnt   = '0;
            next_digit = digit + 3'd1;
            commit     = (digit == 3'd7);
          end else begin
            next_cnt = cnt + CW'(1);
          end
        end
        default: begin
          next_state = ST_OFF;
          next_cnt   = '0;
          next_digit = '0;
        end
      endcase
    end
  end

  // Next output values derived from the current state.
  always_comb begin
    next_an         = 8'hFF;
    next_seg        = SEG_BLANK;
    next_dp         = 1'b1;
    next_frame_done = 1'b0;
    if (i_enable && state == ST_SHOW) begin
      next_an  = ~(8'h01 << digit);
      next_seg = lead_zero ? SEG_BLANK : dec_seg;
      next_dp  = lead_zero | ~i_dp_mask[digit];
      next_frame_done = (digit == 3'd7) && (cnt == FRAME_MARK);
    end
  end

  // Registered display outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_an         <= 8'hFF;
      o_seg        <= SEG_BLANK;
      o_dp         <= 1'b1;
      o_frame_done <= 1'b0;
    end else begin
      o_an         <= next_an;
      o_seg        <= next_seg;
      o_dp         <= next_dp;
      o_frame_done <= next_frame_done;
    end
  end

  // Double buffer: a load on a commit cycle bypasses straight to display.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      display   <= '0;
      pending   <= '0;
      pend_flag <= 1'b0;
    end else if (commit) begin
      if (i_load) begin
        display   <= i_value;
        pending   <= i_value;
        pend_flag <= 1'b0;
      end else if (pend_flag) begin
        display   <= pending;
        pend_flag <= 1'b0;
      end
    end else if (i_load) begin
      pending   <= i_value;
      pend_flag <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: directed scenarios plus random stimulus, checked
// every cycle against a timeline model and pinned by literal expectations.
module tb_seg7_scan_ctrl;

  localparam int D = 10;
  localparam int B = 2;
  localparam int FRAME = 8 * D;
`ifdef SEG7_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [31:0] value = '0;
  logic        load = 1'b0;
  logic [7:0]  mask = '0;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  seg7_scan_ctrl #(.DIGIT_CYCLES(D), .BLANK_CYCLES(B)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_enable     (enable),
    .i_value      (value),
    .i_load       (load),
    .i_dp_mask    (mask),
    .o_an         (an),
    .o_seg        (seg),
    .o_dp         (dp),
    .o_frame_done (frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  logic [6:0] dec_tab [16];
  initial begin
    dec_tab[0]  = 7'b0000001; dec_tab[1]  = 7'b1001111;
    dec_tab[2]  = 7'b0010010; dec_tab[3]  = 7'b0000110;
    dec_tab[4]  = 7'b1001100; dec_tab[5]  = 7'b0100100;
    dec_tab[6]  = 7'b0100000; dec_tab[7]  = 7'b0001111;
    dec_tab[8]  = 7'b0000000; dec_tab[9]  = 7'b0000100;
    dec_tab[10] = 7'b0001000; dec_tab[11] = 7'b1100000;
    dec_tab[12] = 7'b0110001; dec_tab[13] = 7'b1000010;
    dec_tab[14] = 7'b0110000; dec_tab[15] = 7'b0111000;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Model: t counts cycles since the display was (re)enabled; every output
  // is a function of t, the committed value and the inputs.
  bit          armed = 1'b0;
  bit          running;
  int          t;
  int          m_dig;
  bit          m_commit, m_lz;
  logic [31:0] m_disp, m_pend;
  bit          m_flag;
  logic [3:0]  m_nib;
  logic [7:0]  e_an = 8'hFF;
  logic [6:0]  e_seg = 7'h7F;
  logic        e_dp = 1'b1;
  logic        e_fd = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      armed = 1'b1;
      running = 1'b0; t = 0;
      m_disp = '0; m_pend = '0; m_flag = 1'b0;
      e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
    end else begin
      m_dig = (t / D) % 8;
      e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
      if (running && enable && (t % D) >= B) begin
        m_nib = 4'((m_disp >> (4 * m_dig)) & 32'hF);
        m_lz  = LZB && (m_dig > 0) && ((m_disp >> (4 * m_dig)) == 32'd0);
        e_an  = ~(8'h01 << m_dig);
        e_seg = m_lz ? 7'h7F : dec_tab[m_nib];
        e_dp  = m_lz ? 1'b1 : ~mask[m_dig];
        e_fd  = ((t % FRAME) == FRAME - 2);
      end
      m_commit = enable && (!running || (t % FRAME) == FRAME - 1);
      if (!enable) begin
        running = 1'b0; t = 0;
      end else if (!running) begin
        running = 1'b1; t = 0;
      end else begin
        t++;
      end
      if (m_commit) begin
        if (load) begin m_disp = value; m_flag = 1'b0; end
        else if (m_flag) begin m_disp = m_pend; m_flag = 1'b0; end
      end else if (load) begin
        m_pend = value; m_flag = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      check("model_an", {24'd0, an}, {24'd0, e_an});
      check("model_seg", {25'd0, seg}, {25'd0, e_seg});
      check("model_dp", {31'd0, dp}, {31'd0, e_dp});
      check("model_frame_done", {31'd0, frame_done}, {31'd0, e_fd});
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_an(input logic [7:0] tgt, input string nm);
    int n = 0;
    while (an !== tgt && n < 400) begin step(1); n++; end
    check({"reach_", nm}, {24'd0, an}, {24'd0, tgt});
  endtask

  task automatic wait_fd(input string nm);
    int n = 0;
    while (frame_done !== 1'b1 && n < 400) begin step(1); n++; end
    check({"reach_", nm}, {31'd0, frame_done}, 32'd1);
  endtask

  int c1, c2;
  logic [6:0] hi_seg;

  initial begin
    step(3);
    check("reset_an", {24'd0, an}, 32'hFF);
    check("reset_seg", {25'd0, seg}, 32'h7F);
    check("reset_dp", {31'd0, dp}, 32'd1);
    check("reset_fd", {31'd0, frame_done}, 32'd0);
    rst = 1'b0;

    // 1: count-up pattern across a full frame
    value = 32'h76543210; load = 1'b1; step(1); load = 1'b0;
    enable = 1'b1;
    wait_an(8'hFE, "t1_d0");
    check("t1_d0_seg", {25'd0, seg}, {25'd0, 7'b0000001});
    wait_an(8'h7F, "t1_d7");
    check("t1_d7_seg", {25'd0, seg}, {25'd0, 7'b0001111});
    wait_fd("t1_fd_a"); c1 = cyc; step(1);
    wait_fd("t1_fd_b"); c2 = cyc;
    check("t1_fd_period", c2 - c1, 80);

    // 2: load mid-frame waits for frame boundary
    wait_an(8'hF7, "t2_d3");
    value = 32'hFFFFFFFF; load = 1'b1; step(1); load = 1'b0;
    wait_an(8'h7F, "t2_d7_old");
    check("t2_d7_old_seg", {25'd0, seg}, {25'd0, 7'b0001111});
    wait_an(8'hFE, "t2_d0_new");
    check("t2_d0_new_seg", {25'd0, seg}, {25'd0, 7'b0111000});

    // 3: load coinciding with frame_done goes straight to the next frame
    wait_fd("t3_fd");
    value = 32'h11111111; load = 1'b1; step(1); load = 1'b0;
    wait_an(8'hFE, "t3_d0");
    check("t3_d0_seg", {25'd0, seg}, {25'd0, 7'b1001111});
    wait_an(8'h7F, "t3_d7");
    check("t3_d7_seg", {25'd0, seg}, {25'd0, 7'b1001111});

    // 4: disable mid-show, re-enable restarts at digit 0 after blanking
    wait_an(8'hDF, "t4_d5");
    step(2); enable = 1'b0; step(1);
    check("t4_dark_an", {24'd0, an}, 32'hFF);
    check("t4_dark_seg", {25'd0, seg}, 32'h7F);
    step(4); enable = 1'b1; step(3);
    check("t4_blank_an", {24'd0, an}, 32'hFF);
    step(1);
    check("t4_d0_an", {24'd0, an}, 32'hFE);
    check("t4_d0_seg", {25'd0, seg}, {25'd0, 7'b1001111});

    // 5: reset mid-frame
    wait_an(8'hEF, "t5_d4");
    rst = 1'b1; enable = 1'b0; step(1);
    check("t5_rst_an", {24'd0, an}, 32'hFF);
    check("t5_rst_seg", {25'd0, seg}, 32'h7F);
    check("t5_rst_dp", {31'd0, dp}, 32'd1);
    rst = 1'b0; step(2); enable = 1'b1;
    wait_an(8'hFE, "t5_d0");
    check("t5_d0_seg", {25'd0, seg}, {25'd0, 7'b0000001});

    // random traffic, model checks every cycle
    for (int i = 0; i < 1500; i++) begin
      load  = ($urandom_range(0, 29) == 0);
      value = $urandom;
      if ($urandom_range(0, 3) == 0) value = value & 32'h0000FFFF;
      mask  = 8'($urandom);
      if ($urandom_range(0, 199) == 0) enable = ~enable;
      rst   = ($urandom_range(0, 699) == 0);
      step(1);
    end
    load = 1'b0; rst = 1'b0; enable = 1'b0;

    // 6: decimal point and leading-zero handling
    rst = 1'b1; mask = 8'h04; step(1); rst = 1'b0;
    value = 32'h00000A05; load = 1'b1; step(1); load = 1'b0;
    enable = 1'b1;
    hi_seg = LZB ? 7'h7F : 7'b0000001;
    wait_an(8'hFE, "t6_d0");
    check("t6_d0_seg", {25'd0, seg}, {25'd0, 7'b0100100});
    check("t6_d0_dp", {31'd0, dp}, 32'd1);
    wait_an(8'hFD, "t6_d1");
    check("t6_d1_seg", {25'd0, seg}, {25'd0, 7'b0000001});
    wait_an(8'hFB, "t6_d2");
    check("t6_d2_seg", {25'd0, seg}, {25'd0, 7'b0001000});
    check("t6_d2_dp", {31'd0, dp}, 32'd0);
    wait_an(8'hF7, "t6_d3");
    check("t6_d3_seg", {25'd0, seg}, {25'd0, hi_seg});
    check("t6_d3_dp", {31'd0, dp}, 32'd1);
    wait_an(8'h7F, "t6_d7");
    check("t6_d7_seg", {25'd0, seg}, {25'd0, hi_seg});

    step(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
Scan controller for the Nexys A7 8-digit multiplexed 7-segment display, running in the core clock domain. It holds a 32-bit value as 8 hex nibbles and drives one digit at a time. Between digits it inserts an all-off blanking interval to prevent ghosting. New values are double-buffered and committed only at frame boundaries, so a displayed frame never mixes old and new nibbles.

Parameters:
DIGIT_CYCLES, 100000, total clock cycles per digit slot (blank plus show); must be greater than BLANK_CYCLES + 1.
BLANK_CYCLES, 1000, cycles at the start of each slot with all anodes off; must be at least 1.

Ports:
i_clk  in  1  core clock
i_rst  in  1  synchronous reset, active-high
i_enable  in  1  scan enable; low forces the display dark
i_value  in  32  value to display; nibble k is shown on digit k
i_load  in  1  single-cycle strobe; captures i_value into the pending register
i_dp_mask  in  8  decimal-point enable per digit, active-high, sampled live
o_an  out  8  anode selects, active-low
o_seg  out  7  segments, active-low; bit6 = a (ca) down to bit0 = g (cg)
o_dp  out  1  decimal point, active-low
o_frame_done  out  1  one-cycle pulse at the end of the digit-7 show phase

Behaviour:
- Clock and reset: one clock, i_clk. i_rst is synchronous and active-high.
- Reset values: o_an=8'hFF, o_seg=7'h7F, o_dp=1, o_frame_done=0. Display reg=0, pending reg=0, pending flag=0, digit index=0, slot counter=0, state=OFF.
- Outputs are registered: they reflect the state one cycle after a state or counter change.
- States:
  - OFF: o_an=FF, o_seg=7F, o_dp=1. When i_enable=1: commit the pending value, set digit=0, go to BLANK.
  - BLANK: o_an=FF, o_seg=7F. After BLANK_CYCLES cycles, go to SHOW.
  - SHOW: o_an has a single 0 at bit [digit]. o_seg = decode(display[4*digit+:4]). o_dp = ~i_dp_mask[digit]. After DIGIT_CYCLES-BLANK_CYCLES cycles, go to BLANK with digit+1.
- Frame wrap: when digit is 7 at the end of SHOW, digit wraps to 0, o_frame_done pulses, and the pending value is committed.
- Commit: display <= pending only if the pending flag is set; the flag is then cleared.
- Load: i_load sets pending <= i_value and sets the pending flag. If i_load coincides with a commit cycle, i_value goes straight to display and the flag is cleared (newest value wins).
- i_enable=0 in any state: go to OFF on the next cycle. Digit and counter reset to 0; the pending register and flag are kept.
- i_rst mid-frame: everything returns to reset values on the next edge, with no partial-slot completion.
- Decode table, nibble -> o_seg:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
- Slot counter width is $clog2(DIGIT_CYCLES). It compares for equality only and never overflows.

Optional Feature:
SEG7_LZB_EN — leading-zero blanking.
- Defined: in SHOW, a digit k>0 whose nibbles k..7 of display are all zero outputs o_seg=7F and o_dp=1. Its anode still strobes to keep brightness uniform. Digit 0 always shows.
- Undefined: all 8 digits always show their decoded nibble.

Decomposition:
- Package seg7_pkg holds:
  - the state enum (OFF, BLANK, SHOW),
  - SEG_BLANK = 7'h7F,
  - the 16-entry decode constant.
- One sub-module, seg7_hex_decode: purely combinational, 4-bit nibble -> 7-bit active-low segments, instantiated once on the selected nibble.

Test Plan:
Bench parameters: DIGIT_CYCLES=10, BLANK_CYCLES=2.
1. Reset, i_load with 0x76543210, i_enable=1 → per slot: 2 cycles o_an=FF, then 8 cycles with o_an low at bit k and o_seg = decode(k). Digit 0 shows 0000001, digit 7 shows 0001111. o_frame_done pulses every 80 cycles.
2. With 0x76543210 displayed, i_load 0xFFFFFFFF during digit 3 SHOW → digits 3–7 still show old nibbles; the next frame shows all digits as 0111000.
3. i_load 0x11111111 on the exact cycle o_frame_done is asserted → the next frame shows all digits as 1001111, and the pending flag is clear afterwards.
4. i_enable dropped mid-SHOW on digit 5 → next cycle o_an=FF, o_seg=7F. Re-enable → 2-cycle BLANK, then digit 0 shows.
5. i_rst asserted mid-frame → next cycle all outputs at reset values; after re-enable with no load, digit 0 shows 0000001.
6. i_dp_mask=8'h04 with value 0x00000A05:
   - with SEG7_LZB_EN: digits 0–2 show 5, 0, A; digits 3–7 show 7F; o_dp=0 only during digit 2 SHOW.
   - without SEG7_LZB_EN: digits 3–7 show 0000001.
